// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between NUM_REQ requesters, with inter-frame gap and hung-frame watchdog.
// Optional packet lock (no interleaving of multi-byte packets) enabled by defining UART_ARB_PKT_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 131071
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       timeout_err,
  output logic [7:0]                 err_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0] ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_ptr;
  logic [WD_W-1:0]   r_wd;
  logic [GC_W-1:0]   r_gap;
  logic [NUM_REQ-1:0] w_cand;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_idx;
  logic              w_found;
  logic              w_grant;
  logic              w_done;
  logic              w_expire;
  logic              w_adv_ptr;

`ifdef UART_ARB_PKT_LOCK_EN
  logic              r_lock;
  logic [ID_W-1:0]   r_lock_id;

  // While a packet is open only its owner competes, and the pointer stays put.
  assign w_cand    = r_lock ? (req_valid & (NUM_REQ'(1) << r_lock_id)) : req_valid;
  assign w_adv_ptr = !r_lock;
`else
  logic              w_unused_last;

  assign w_unused_last = ^req_last;
  assign w_cand        = req_valid;
  assign w_adv_ptr     = 1'b1;
`endif

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_grant  = (r_state == S_IDLE) && !tx_busy && w_found;
  assign w_done   = (r_state == S_WAIT) && tx_done;
  // Done in the expiry cycle takes precedence over the abort.
  assign w_expire = (r_state == S_WAIT) && !tx_done && (r_wd == WD_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (w_done || w_expire) w_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:    if (r_gap == GAP_LAST) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_wd        <= '0;
      r_gap       <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      r_state     <= w_next;
      tx_start    <= w_grant;
      req_ready   <= w_grant ? (NUM_REQ'(1) << w_win) : '0;
      active      <= (w_next == S_LAUNCH) || (w_next == S_WAIT);
      timeout_err <= w_expire;
      if (w_grant) begin
        tx_data  <= req_data[int'(w_win)*DATA_W +: DATA_W];
        grant_id <= w_win;
      end
      if (w_expire && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
      // Watchdog measures cycles since tx_start: 0 in LAUNCH, 1 in the first WAIT cycle.
      if (w_grant)
        r_wd <= '0;
      else if ((r_state == S_LAUNCH) || (r_state == S_WAIT))
        r_wd <= r_wd + 1'b1;
      if (r_state == S_GAP)
        r_gap <= r_gap + 1'b1;
      else
        r_gap <= '0;
      if ((r_state == S_LAUNCH) && w_adv_ptr)
        r_ptr <= (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
    end
  end

`ifdef UART_ARB_PKT_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else if (w_grant) begin
      r_lock    <= !req_last[w_win];
      r_lock_id <= w_win;
    end else if (w_expire) begin
      r_lock    <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: NUM_REQ=4, GAP_CYCLES=5, TIMEOUT_CYCLES=64, hand-driven TX core stub.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(5), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .active(active), .timeout_err(timeout_err),
    .err_cnt(err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max, output int n);
    n = 0;
    while ((tx_start !== 1'b1) && (n < max)) begin
      tick();
      n++;
    end
    if (tx_start !== 1'b1) check_eq("start_bound", 32'(tx_start), 32'd1);
  endtask

  // TX stub frame: busy for len cycles, done pulse sampled on the last one.
  task automatic do_frame(input int len, output int extra);
    extra = 0;
    tx_busy = 1'b1;
    for (int i = 0; i < len - 1; i++) begin
      tick();
      if (tx_start || (req_ready != 4'd0)) extra++;
    end
    tx_done = 1'b1;
    tick();
    if (tx_start || (req_ready != 4'd0)) extra++;
    tx_done = 1'b0;
    tx_busy = 1'b0;
  endtask

  task automatic one_timeout(output int n);
    tx_busy = 1'b1;
    n = 0;
    while ((timeout_err !== 1'b1) && (n < 200)) begin
      tick();
      n++;
    end
    if (timeout_err !== 1'b1) check_eq("timeout_bound", 32'(timeout_err), 32'd1);
    tx_busy = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    logic [7:0] rr_exp [5];
    logic [1:0] lk_exp [4];
    int n;
    int extra;
    int sent0;

    rr_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`ifdef UART_ARB_PKT_LOCK_EN
    lk_exp = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
    lk_exp = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif

    rst = 1'b1; req_valid = '0; req_data = 32'h44332211; req_last = '0;
    tx_busy = 1'b0; tx_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_active", 32'(active), 32'd0);
    check_eq("rst_timeout", 32'(timeout_err), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Round-robin over four always-valid requesters.
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_start(40, n);
      check_eq($sformatf("rr_data%0d", f), 32'(tx_data), 32'(rr_exp[f]));
      check_eq($sformatf("rr_ready%0d", f), 32'(req_ready), 32'(4'd1 << (f % 4)));
      check_eq($sformatf("rr_gid%0d", f), 32'(grant_id), 32'(f % 4));
      check_eq($sformatf("rr_active%0d", f), 32'(active), 32'd1);
      if (f == 4) req_valid = 4'b0000;
      do_frame(20, extra);
      check_eq($sformatf("rr_extra%0d", f), 32'(extra), 32'd0);
    end
    repeat (10) tick();

    // Latency and gap with a single continuously-valid requester.
    req_valid = 4'b0100;
    req_data  = 32'h00340000;
    wait_start(40, n);
    check_eq("lat_cycles", 32'(n), 32'd1);
    check_eq("lat_data", 32'(tx_data), 32'h34);
    check_eq("lat_gid", 32'(grant_id), 32'd2);
    do_frame(10, extra);
    wait_start(40, n);
    check_eq("gap_cycles", 32'(n), 32'd6);
    check_eq("gap_data", 32'(tx_data), 32'h34);
    check_eq("gap_gid", 32'(grant_id), 32'd2);
    req_valid = 4'b0000;
    do_frame(10, extra);
    repeat (10) tick();

    // Watchdog abort on a frame that never completes.
    req_data  = 32'h44332211;
    req_valid = 4'b0010;
    wait_start(40, n);
    req_valid = 4'b0000;
    tx_busy = 1'b1;
    n = 0;
    while ((timeout_err !== 1'b1) && (n < 200)) begin
      tick();
      n++;
    end
    check_eq("wd_cycles", 32'(n), 32'd64);
    check_eq("wd_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("wd_active", 32'(active), 32'd0);
    tick();
    check_eq("wd_pulse_len", 32'(timeout_err), 32'd0);
    tx_busy = 1'b0;
    repeat (10) tick();

    // tx_done arriving in the expiry cycle wins over the watchdog.
    req_valid = 4'b0001;
    wait_start(40, n);
    req_valid = 4'b0000;
    tx_busy = 1'b1;
    repeat (63) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_busy = 1'b0;
    check_eq("col_timeout", 32'(timeout_err), 32'd0);
    check_eq("col_active", 32'(active), 32'd0);
    check_eq("col_err_cnt", 32'(err_cnt), 32'd1);
    tick();
    check_eq("col_timeout2", 32'(timeout_err), 32'd0);
    repeat (10) tick();

    // No grant while the TX core reports busy.
    tx_busy = 1'b1;
    req_valid = 4'b0010;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_start) extra++;
    end
    check_eq("busy_no_grant", 32'(extra), 32'd0);
    tx_busy = 1'b0;
    wait_start(40, n);
    check_eq("busy_release", 32'(n), 32'd1);
    check_eq("busy_gid", 32'(grant_id), 32'd1);
    req_valid = 4'b0000;
    one_timeout(n);
    check_eq("sat_err2", 32'(err_cnt), 32'd2);

    // Saturation of the timeout counter.
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'b0001;
      wait_start(40, n);
      req_valid = 4'b0000;
      one_timeout(n);
      if (i == 251) check_eq("sat_err254", 32'(err_cnt), 32'd254);
    end
    check_eq("sat_err255", 32'(err_cnt), 32'd255);

    // Reset in the middle of a frame; TX core still busy afterwards.
    req_valid = 4'b0100;
    wait_start(40, n);
    req_valid = 4'b0000;
    tx_busy = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_active", 32'(active), 32'd0);
    check_eq("mrst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("mrst_tx_data", 32'(tx_data), 32'd0);
    check_eq("mrst_grant_id", 32'(grant_id), 32'd0);
    req_valid = 4'b0001;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_start) extra++;
    end
    check_eq("mrst_no_grant", 32'(extra), 32'd0);
    tx_busy = 1'b0;
    wait_start(40, n);
    check_eq("mrst_release", 32'(n), 32'd1);
    check_eq("mrst_data", 32'(tx_data), 32'h11);
    req_valid = 4'b0000;
    do_frame(10, extra);
    repeat (10) tick();

    // Packet lock: req0 sends three bytes while req1 waits.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_last  = 4'b0000;
    req_valid = 4'b0011;
    sent0 = 0;
    for (int f = 0; f < 4; f++) begin
      wait_start(40, n);
      check_eq($sformatf("lock_gid%0d", f), 32'(grant_id), 32'(lk_exp[f]));
      if (grant_id == 2'd0) begin
        sent0++;
        req_last[0] = (sent0 == 2);
      end
      do_frame(10, extra);
    end
    req_valid = 4'b0000;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter core (9600 baud, 8N1) between NUM_REQ requesters (status reporter, RX echo, 7-seg debug dump, etc.).
- Arbitrates round-robin, one byte per grant.
- Launches each byte with a start pulse, tracks completion, enforces an inter-frame gap, and aborts a hung frame with a watchdog.
- Sits between requester logic in TOP and the UART TX datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- GAP_CYCLES, 0, idle clk cycles enforced after each frame before the next grant (0 = none).
- TIMEOUT_CYCLES, 131071, max clk cycles from tx_start to tx_done before abort; 10-bit frame ≈ 104170 cycles at 100 MHz.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  NUM_REQ*DATA_W  packed; requester i byte at [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte is last of a packet; used only with the optional feature.
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse.
- tx_start  out  1  1-cycle launch pulse to the TX core.
- tx_data  out  DATA_W  byte to the TX core; held from tx_start until the next grant.
- tx_busy  in  1  TX core is shifting a frame.
- tx_done  in  1  1-cycle pulse at end of the stop bit.
- grant_id  out  clog2(NUM_REQ)  index of the current/last granted requester.
- active  out  1  high in LAUNCH and WAIT.
- timeout_err  out  1  1-cycle pulse on watchdog abort.
- err_cnt  out  8  saturating count of timeouts.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE, rr pointer 0, all outputs 0. The TX core is not aborted; IDLE therefore waits for tx_busy=0.
- All outputs are registered.
- IDLE: if tx_busy=0 and any req_valid is set:
  - select winner w = first set bit searching from pointer upward, wrapping at NUM_REQ-1 → 0;
  - capture req_data[w] into tx_data; set grant_id=w; go to LAUNCH.
  - req_valid sampled in this cycle is final; dropping it later does not cancel the grant.
- LAUNCH (1 cycle): tx_start=1, req_ready[w]=1, active=1; pointer ← (w+1) mod NUM_REQ; go to WAIT.
  - Latency: valid seen in IDLE at cycle T → tx_start/req_ready at T+1.
- WAIT: active=1; watchdog counts from 0.
  - tx_done=1 → GAP, or IDLE if GAP_CYCLES=0.
  - Watchdog reaches TIMEOUT_CYCLES-1 without tx_done → timeout_err pulse, err_cnt+1 (saturates at 255), then GAP/IDLE.
  - tx_done and timeout in the same cycle → done wins, no error.
- GAP: count GAP_CYCLES cycles, then IDLE. No grants during GAP.
- tx_done outside WAIT is ignored.
- Requesters must hold req_data stable while req_valid=1 and req_ready has not yet pulsed.
- Single requester continuously valid: granted every frame, pointer wraps correctly.
- Starvation bound: any valid requester is granted within NUM_REQ frames.

Optional Feature:
- Macro: UART_ARB_PKT_LOCK_EN.
- Defined:
  - A grant with req_last[w]=0 sets lock=w; while locked, IDLE considers only requester w, and the pointer is not advanced.
  - Lock clears after sending a byte with req_last[w]=1, or on timeout_err.
  - Multi-byte packets are therefore never interleaved.
- Undefined: req_last ignored; pure per-byte round-robin; no lock register.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, no valids → all outputs 0, state IDLE. rst mid-WAIT → outputs 0 next cycle; no grant until tx_busy=0.
- Round-robin: NUM_REQ=4, TX stub with 20-cycle frames, all valid, data 0x11/0x22/0x33/0x44 → tx_data sequence 0x11,0x22,0x33,0x44,0x11; req_ready one-hot, one pulse per frame.
- Latency/gap: GAP_CYCLES=5, req 2 only, data 0x34 → tx_start exactly 1 cycle after valid sampled; next tx_start no earlier than 6 cycles after tx_done.
- Watchdog: TIMEOUT_CYCLES=64, stub never pulses tx_done → timeout_err at cycle 64 after tx_start, err_cnt=1; 300 forced timeouts → err_cnt=255.
- Collision: tx_done and watchdog expiry in the same cycle → no timeout_err, err_cnt unchanged. tx_busy=1 in IDLE → no grant.
- Pkt lock (UART_ARB_PKT_LOCK_EN): req0 sends 3 bytes (last on 3rd) while req1 is valid → order req0,req0,req0,req1. Without the macro → req0,req1,req0,req1….
